// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that funnels NREQ requesters onto one APB master port.
// Performs one transfer at a time: IDLE -> SETUP -> ACCESS, with a wait-state timeout.
module apb_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TMO  = 16
) (
  input  logic                 Pclk,
  input  logic                 Prst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [32*NREQ-1:0]   req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [31:0]          Paddr,
  output logic                 PSELx,
  output logic                 P_en,
  output logic                 P_WR,
  output logic [31:0]          PWdata,
  input  logic [31:0]          PRdata,
  input  logic                 P_ready,
  input  logic                 P_slverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic [4:0]      cnt_q, cnt_d;

  logic            any_req;
  logic            hi_found;
  logic [IW-1:0]   hi_pick;
  logic [IW-1:0]   lo_pick;
  logic [IW-1:0]   pick;

  logic            xfer_ok;
  logic            xfer_tmo;
  logic            xfer_done;

  // Two passes folded into one loop: lowest requester at or above ptr wins,
  // otherwise wrap around to the lowest requester overall.
  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        lo_pick = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_pick  = IW'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  assign xfer_ok   = (state_q == ACCESS) && P_ready;
  assign xfer_tmo  = (state_q == ACCESS) && !P_ready && (cnt_q == 5'(TMO - 1));
  assign xfer_done = xfer_ok || xfer_tmo;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          addr_d  = req_addr[32*int'(pick) +: 32];
          wdata_d = req_wdata[32*int'(pick) +: 32];
          wr_d    = req_wr[pick];
          cnt_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        state_d = ACCESS;
      end

      ACCESS: begin
        if (xfer_done) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  // NOTE: the grant registers are small datapath flops, not a memory array,
  // so they are cleared on reset along with the control state.
  always_ff @(posedge Pclk) begin
    if (Prst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus outputs are masked whenever no transfer is in flight.
  always_comb begin
    PSELx  = (state_q != IDLE);
    P_en   = (state_q == ACCESS);
    Paddr  = PSELx ? addr_q  : '0;
    PWdata = PSELx ? wdata_q : '0;
    P_WR   = PSELx ? wr_q    : 1'b0;
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++) begin
      ack[i] = xfer_done && (gnt_q == IW'(i));
    end
    rsp_err   = xfer_tmo || (xfer_ok && P_slverr);
    rsp_rdata = (xfer_ok && !wr_q) ? PRdata : '0;
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed self-checking bench for apb_rr_arbiter: reset, single read, round-robin,
// wait states with slave error, timeout, dropped request and reset mid-transfer.
module tb_apb_rr_arbiter;

  logic          Pclk;
  logic          Prst;
  logic [3:0]    req;
  logic [3:0]    req_wr;
  logic [127:0]  req_addr;
  logic [127:0]  req_wdata;
  logic [3:0]    ack;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [31:0]   Paddr;
  logic          PSELx;
  logic          P_en;
  logic          P_WR;
  logic [31:0]   PWdata;
  logic [31:0]   PRdata;
  logic          P_ready;
  logic          P_slverr;

  int n_tests = 0;
  int n_fail  = 0;

  apb_rr_arbiter #(.NREQ(4), .TMO(16)) dut (
    .Pclk      (Pclk),
    .Prst      (Prst),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .Paddr     (Paddr),
    .PSELx     (PSELx),
    .P_en      (P_en),
    .P_WR      (P_WR),
    .PWdata    (PWdata),
    .PRdata    (PRdata),
    .P_ready   (P_ready),
    .P_slverr  (P_slverr)
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  // Snapshot layout: {PSELx, P_en, P_WR, Paddr, PWdata, ack, rsp_err, rsp_rdata}
  function automatic logic [103:0] snap();
    return {PSELx, P_en, P_WR, Paddr, PWdata, ack, rsp_err, rsp_rdata};
  endfunction

  function automatic logic [103:0] mk(input logic sel, input logic en, input logic wr,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      input logic [3:0] ak, input logic er,
                                      input logic [31:0] rd);
    return {sel, en, wr, a, wd, ak, er, rd};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge Pclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_slot(input int i, input logic w, input logic [31:0] a,
                          input logic [31:0] wd);
    req_wr[i]             = w;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = wd;
  endtask

  task automatic reset_dut();
    step();
    Prst    = 1'b1;
    req     = '0;
    P_ready = 1'b0;
    step();
    Prst    = 1'b0;
  endtask

  task automatic test_reset();
    logic [103:0] g;
    Prst = 1'b1; req = 4'b1111; P_ready = 1'b1; P_slverr = 1'b1; PRdata = 32'hFFFF_FFFF;
    step();
    step();
    settle();
    g = snap();
    n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL rst_hold: got %h exp %h", g, 104'h0); end
    Prst = 1'b0; req = '0; P_ready = 1'b0; P_slverr = 1'b0; PRdata = '0;
    step();
    settle();
    g = snap();
    n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL rst_idle: got %h exp %h", g, 104'h0); end
  endtask

  task automatic test_single_read();
    logic [103:0] g, e;
    step();
    set_slot(0, 1'b0, 32'h0000_A000, 32'h0);
    req = 4'b0001; PRdata = 32'h0000_1234; P_ready = 1'b1;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL rd_idle: got %h exp %h", g, 104'h0); end

    step(); settle();
    e = mk(1, 0, 0, 32'h0000_A000, 32'h0, 4'b0000, 0, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL rd_setup: got %h exp %h", g, e); end

    step(); settle();
    e = mk(1, 1, 0, 32'h0000_A000, 32'h0, 4'b0001, 0, 32'h0000_1234);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL rd_access: got %h exp %h", g, e); end

    step();
    req = '0; P_ready = 1'b0;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL rd_done: got %h exp %h", g, 104'h0); end
  endtask

  task automatic test_round_robin();
    logic [103:0] g, e;
    int phase, gi;
    reset_dut();
    for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 32'h0000_1000 * (i + 1), 32'h0);
    PRdata = 32'hCAFE_0000; P_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      step();
      if (c == 0) req = 4'b1111;
      settle();
      phase = c % 3;
      gi    = (c / 3) % 4;
      if (phase == 0)
        e = '0;
      else if (phase == 1)
        e = mk(1, 0, 0, 32'h0000_1000 * (gi + 1), 32'h0, 4'b0000, 0, 32'h0);
      else
        e = mk(1, 1, 0, 32'h0000_1000 * (gi + 1), 32'h0, 4'(1 << gi), 0, 32'hCAFE_0000);
      g = snap(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL rr_cycle%0d: got %h exp %h", c, g, e); end
    end
    step();
    req = '0; P_ready = 1'b0;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL rr_end: got %h exp %h", g, 104'h0); end
  endtask

  task automatic test_wait_err();
    logic [103:0] g, e;
    step();
    set_slot(2, 1'b1, 32'h0000_C008, 32'hDEAD_BEEF);
    req = 4'b0100; P_ready = 1'b0; P_slverr = 1'b0; PRdata = 32'h0000_5555;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL we_idle: got %h exp %h", g, 104'h0); end

    step();
    set_slot(2, 1'b0, 32'hFFFF_FFFF, 32'h0);
    settle();
    e = mk(1, 0, 1, 32'h0000_C008, 32'hDEAD_BEEF, 4'b0000, 0, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL we_setup: got %h exp %h", g, e); end

    for (int w = 0; w < 3; w++) begin
      step(); settle();
      e = mk(1, 1, 1, 32'h0000_C008, 32'hDEAD_BEEF, 4'b0000, 0, 32'h0);
      g = snap(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL we_wait%0d: got %h exp %h", w, g, e); end
    end

    step();
    P_ready = 1'b1; P_slverr = 1'b1;
    settle();
    e = mk(1, 1, 1, 32'h0000_C008, 32'hDEAD_BEEF, 4'b0100, 1, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL we_ack: got %h exp %h", g, e); end

    step();
    req = '0; P_ready = 1'b0; P_slverr = 1'b0;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL we_done: got %h exp %h", g, 104'h0); end
  endtask

  task automatic test_timeout();
    logic [103:0] g, e;
    step();
    set_slot(0, 1'b0, 32'h0000_A000, 32'h0);
    req = 4'b0001; PRdata = 32'hFFFF_FFFF; P_ready = 1'b0;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL to_idle: got %h exp %h", g, 104'h0); end

    step(); settle();
    e = mk(1, 0, 0, 32'h0000_A000, 32'h0, 4'b0000, 0, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL to_setup: got %h exp %h", g, e); end

    for (int a = 1; a <= 16; a++) begin
      step(); settle();
      if (a == 16) e = mk(1, 1, 0, 32'h0000_A000, 32'h0, 4'b0001, 1, 32'h0);
      else         e = mk(1, 1, 0, 32'h0000_A000, 32'h0, 4'b0000, 0, 32'h0);
      g = snap(); n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL to_access%0d: got %h exp %h", a, g, e); end
    end

    step();
    req = '0;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL to_done: got %h exp %h", g, 104'h0); end
  endtask

  task automatic test_drop_req();
    logic [103:0] g, e;
    step();
    set_slot(1, 1'b1, 32'h0000_B004, 32'h0BAD_F00D);
    req = 4'b0010; P_ready = 1'b0; PRdata = 32'h0000_1111;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL dr_idle: got %h exp %h", g, 104'h0); end

    step();
    req = '0;
    settle();
    e = mk(1, 0, 1, 32'h0000_B004, 32'h0BAD_F00D, 4'b0000, 0, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL dr_setup: got %h exp %h", g, e); end

    step();
    P_ready = 1'b1;
    settle();
    e = mk(1, 1, 1, 32'h0000_B004, 32'h0BAD_F00D, 4'b0010, 0, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL dr_ack: got %h exp %h", g, e); end

    step();
    P_ready = 1'b0;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL dr_done: got %h exp %h", g, 104'h0); end
  endtask

  task automatic test_reset_mid();
    logic [103:0] g, e;
    step();
    set_slot(3, 1'b0, 32'h0000_D00C, 32'h0);
    req = 4'b1010; P_ready = 1'b0; PRdata = 32'h0;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL rm_idle: got %h exp %h", g, 104'h0); end

    step(); settle();
    e = mk(1, 0, 0, 32'h0000_D00C, 32'h0, 4'b0000, 0, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL rm_setup: got %h exp %h", g, e); end

    step(); settle();
    e = mk(1, 1, 0, 32'h0000_D00C, 32'h0, 4'b0000, 0, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL rm_wait1: got %h exp %h", g, e); end

    step();
    Prst = 1'b1;
    settle();
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL rm_wait2: got %h exp %h", g, e); end

    step();
    Prst = 1'b0;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL rm_after: got %h exp %h", g, 104'h0); end

    step(); settle();
    e = mk(1, 0, 1, 32'h0000_B004, 32'h0BAD_F00D, 4'b0000, 0, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL rm_regrant: got %h exp %h", g, e); end

    step();
    P_ready = 1'b1;
    settle();
    e = mk(1, 1, 1, 32'h0000_B004, 32'h0BAD_F00D, 4'b0010, 0, 32'h0);
    g = snap(); n_tests++;
    if (g !== e) begin n_fail++; $display("FAIL rm_ack: got %h exp %h", g, e); end

    step();
    req = '0; P_ready = 1'b0;
    settle();
    g = snap(); n_tests++;
    if (g !== '0) begin n_fail++; $display("FAIL rm_done: got %h exp %h", g, 104'h0); end
  endtask

  initial begin
    Prst      = 1'b1;
    req       = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    PRdata    = '0;
    P_ready   = 1'b0;
    P_slverr  = 1'b0;

    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_err();
    test_timeout();
    test_drop_req();
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
